// File: rtl/pix_frame_sink_pkg.sv
// Shared types and constants for the SDL pixel-stream frame sink.
// Summary field widths match the default CORDW=10 / CNTW=19 build.
package pix_frame_sink_pkg;

  localparam int CORDW_P = 10;
  localparam int CNTW_P  = 19;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic {SEEK, ACCUM} state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef struct packed {
    logic [CORDW_P-1:0] min_x;
    logic [CORDW_P-1:0] max_x;
    logic [CORDW_P-1:0] min_y;
    logic [CORDW_P-1:0] max_y;
    logic [CNTW_P-1:0]  key_cnt;
    logic               found;
    logic               err;
    logic [15:0]        crc;
  } frm_sum_t;

  localparam frm_sum_t SUM_RST = '{
    min_x: '1, max_x: '0, min_y: '1, max_y: '0,
    key_cnt: '0, found: 1'b0, err: 1'b0, crc: 16'h0000
  };

  localparam frm_sum_t ACC_CLR = '{
    min_x: '1, max_x: '0, min_y: '1, max_y: '0,
    key_cnt: '0, found: 1'b0, err: 1'b0, crc: CRC_INIT
  };

endpackage

// File: rtl/pix_crc16_step.sv
// CRC-16-CCITT update over one 24-bit pixel, r then g then b, MSB first.
// Purely combinational; one instance advances the CRC by a whole pixel.
module pix_crc16_step
  import pix_frame_sink_pkg::*;
(
  input  logic [15:0] crc_i,
  input  rgb24_t      data_i,
  output logic [15:0] crc_o
);

  logic [23:0] d;
  assign d = data_i;

  always_comb begin
    logic fb;
    crc_o = crc_i;
    for (int i = 23; i >= 0; i--) begin
      fb    = crc_o[15] ^ d[i];
      crc_o = {crc_o[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/pix_frame_sink.sv
// Frame sink: raster-order check, key-colour box/count, per-frame summary.
// Define PIX_FRAME_SINK_CRC_EN to build the per-frame CRC-16 accumulator.
module pix_frame_sink
  import pix_frame_sink_pkg::*;
#(
  parameter int          CORDW   = 10,
  parameter int          H_RES   = 640,
  parameter int          V_RES   = 480,
  parameter int          CNTW    = 19,
  parameter logic [23:0] KEY_RGB = 24'hFFFFFF
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] in_sx,
  input  logic [CORDW-1:0] in_sy,
  input  logic             in_de,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  output logic             frm_valid,
  input  logic             frm_ready,
  output logic [CORDW-1:0] frm_min_x,
  output logic [CORDW-1:0] frm_max_x,
  output logic [CORDW-1:0] frm_min_y,
  output logic [CORDW-1:0] frm_max_y,
  output logic [CNTW-1:0]  frm_key_cnt,
  output logic             frm_found,
  output logic             frm_err,
  output logic [15:0]      frm_crc,
  output logic             frm_drop
);

  localparam logic [CORDW-1:0] XL = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] YL = CORDW'(V_RES - 1);

  state_e           state_q;
  logic [CORDW-1:0] ex_q, ey_q, ex_d, ey_d;
  frm_sum_t         acc_q, pend_q, sum_q;
  frm_sum_t         base, acc_d, cut;
  logic             pub_q, valid_q, drop_q;
  logic             sof, eof, key, restart, mism;
  logic [15:0]      crc_d;
  rgb24_t           px;

  assign px = {in_r, in_g, in_b};

`ifdef PIX_FRAME_SINK_CRC_EN
  pix_crc16_step u_crc (
    .crc_i  (base.crc),
    .data_i (px),
    .crc_o  (crc_d)
  );
`else
  assign crc_d = 16'h0000;
`endif

  always_comb begin
    sof     = (in_sx == '0) && (in_sy == '0);
    eof     = (in_sx == XL) && (in_sy == YL);
    key     = (px == KEY_RGB);
    restart = (state_q == ACCUM) && sof;
    mism    = (state_q == ACCUM) && !sof &&
              ((in_sx != ex_q) || (in_sy != ey_q));
    ex_d    = (in_sx == XL) ? '0 : in_sx + 1'b1;
    ey_d    = (in_sx == XL) ? in_sy + 1'b1 : in_sy;
    // A premature restart folds (0,0) into a fresh frame
    base    = restart ? ACC_CLR : acc_q;
    acc_d   = base;
    acc_d.err = base.err | mism;
    if (key) begin
      if (base.key_cnt != '1) acc_d.key_cnt = base.key_cnt + 1'b1;
      if (in_sx < base.min_x) acc_d.min_x = in_sx;
      if (in_sx > base.max_x) acc_d.max_x = in_sx;
      if (in_sy < base.min_y) acc_d.min_y = in_sy;
      if (in_sy > base.max_y) acc_d.max_y = in_sy;
    end
    acc_d.crc   = crc_d;
    acc_d.found = (acc_d.key_cnt != '0);
    cut     = acc_q;
    cut.err = 1'b1;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q <= SEEK;
      ex_q    <= '0;
      ey_q    <= '0;
      acc_q   <= ACC_CLR;
      pend_q  <= SUM_RST;
      sum_q   <= SUM_RST;
      pub_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pub_q <= 1'b0;
      if (in_de) begin
        ex_q <= ex_d;
        ey_q <= ey_d;
        unique case (state_q)
          SEEK: begin
            if (sof) begin
              acc_q   <= acc_d;
              state_q <= ACCUM;
            end
          end
          ACCUM: begin
            if (restart) begin
              pend_q <= cut;
              pub_q  <= 1'b1;
              acc_q  <= acc_d;
            end else if (eof) begin
              pend_q  <= acc_d;
              pub_q   <= 1'b1;
              acc_q   <= ACC_CLR;
              state_q <= SEEK;
            end else begin
              acc_q <= acc_d;
            end
          end
        endcase
      end
      // Output register: load, hold under backpressure, or drop
      if (pub_q && (!valid_q || frm_ready)) begin
        sum_q   <= pend_q;
        valid_q <= 1'b1;
      end else if (pub_q) begin
        drop_q <= 1'b1;
      end else if (valid_q && frm_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign frm_valid   = valid_q;
  assign frm_drop    = drop_q;
  assign frm_min_x   = sum_q.min_x;
  assign frm_max_x   = sum_q.max_x;
  assign frm_min_y   = sum_q.min_y;
  assign frm_max_y   = sum_q.max_y;
  assign frm_key_cnt = sum_q.key_cnt;
  assign frm_found   = sum_q.found;
  assign frm_err     = sum_q.err;
  assign frm_crc     = sum_q.crc;

endmodule

// File: doc/pix_frame_sink.md
Name: pix_frame_sink

Overview:
- Receiving end of the registered SDL pixel stream (coordinates, data enable, 8-bit RGB) that the display generators drive at pixel-clock rate.
- Consumes one pixel per cycle and checks raster order against the expected 640x480 scan.
- Per frame it accumulates:
  - the bounding box and count of pixels matching a key colour;
  - an optional CRC.
- Hands a per-frame summary to the sim harness or a checker over a valid/ready interface.

Parameters:
- CORDW, 10, coordinate width.
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- CNTW, 19, key-pixel counter width; must hold H_RES*V_RES.
- KEY_RGB, 24'hFFFFFF, key colour, order {r,g,b}.

Ports:
- clk_pix  in  1  pixel clock; all logic on rising edge.
- rst_pix  in  1  reset, asynchronous, active-high.
- in_sx  in  CORDW  pixel horizontal position.
- in_sy  in  CORDW  pixel vertical position.
- in_de  in  1  data enable; pixel sampled only when 1.
- in_r / in_g / in_b  in  8 each  pixel colour.
- frm_valid  out  1  summary available.
- frm_ready  in  1  consumer accepts summary.
- frm_min_x / frm_max_x  out  CORDW  key bounding box, x.
- frm_min_y / frm_max_y  out  CORDW  key bounding box, y.
- frm_key_cnt  out  CNTW  number of key-colour pixels.
- frm_found  out  1  key count non-zero.
- frm_err  out  1  raster-order violation in this frame.
- frm_crc  out  16  frame CRC.
- frm_drop  out  1  sticky: a summary was discarded.

Behaviour:
- Reset (async assert, sync release): state SEEK; frm_valid=0, frm_drop=0. All frm_* outputs 0, except frm_min_x/frm_min_y, which are all ones.
- Accumulators are cleared to:
  - min = all ones, max = 0, count = 0;
  - crc = 16'hFFFF, err = 0;
  - expected position (0,0).
- Cycles with in_de=0 are ignored entirely; coordinates are not checked.
- SEEK state:
  - waits for in_de=1 with in_sx=0 and in_sy=0 (start of frame);
  - that pixel is accumulated and the state moves to ACCUM;
  - all other pixels are discarded, so a partial first frame is never reported.
- ACCUM state, per de pixel:
  - if (in_sx,in_sy) != expected, set err; expected then resyncs to in_sx+1 (or to next line at H_RES-1);
  - expected advances x, wrapping at H_RES-1 to x=0, y+1.
  - Key match means {in_r,in_g,in_b}==KEY_RGB. On a match: count+1, min/max updated with unsigned compares on in_sx/in_sy.
  - Frame end is a de pixel at (H_RES-1, V_RES-1). On it:
    - accumulate that pixel;
    - publish the summary on the next edge;
    - clear the accumulators;
    - return to SEEK.
  - A start-of-frame pixel (0,0) seen in ACCUM other than as the first pixel is a premature restart. On it:
    - publish the current summary with frm_err=1;
    - clear the accumulators;
    - accumulate (0,0) as the first pixel of the new frame;
    - stay in ACCUM.
- Latency: frm_valid rises exactly 1 cycle after the final pixel is sampled.
- Handshake:
  - The summary is held stable while frm_valid=1 && frm_ready=0.
  - A transfer completes on an edge where both are 1.
  - If a publish coincides with a transfer, the new summary loads and frm_valid stays 1.
  - If a publish arrives while frm_valid=1 && frm_ready=0, the new summary is discarded and frm_drop is set; frm_drop clears only on reset.
- frm_found is registered with the summary and equals (frm_key_cnt != 0).
- With no key pixels, min = all ones and max = 0.
- The count saturates at 2^CNTW-1; it cannot overflow with the defaults.

Optional Feature:
- Macro PIX_FRAME_SINK_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 16'h1021, init 16'hFFFF, no reflection, no final xor);
  - computed over every accumulated pixel, 24 bits per pixel, order r,g,b, MSB first;
  - updated in the same cycle the pixel is sampled.
- Undefined: no CRC logic is built and frm_crc is constant 16'h0000.

Decomposition:
- Package pix_frame_sink_pkg holds:
  - state enum {SEEK, ACCUM};
  - CRC_POLY and CRC_INIT constants;
  - an rgb24_t packed struct;
  - a frame-summary packed struct used for the output register.
- One sub-module, pix_crc16_step: combinational 24-bit-per-cycle CRC-16 update, instantiated only under the macro.

Test Plan:
1. White 199x199 square (x 221..419, y 141..339) on blue background, frm_ready=1 → one summary 1 cycle after pixel (639,479): min_x=221, max_x=419, min_y=141, max_y=339, key_cnt=39601, found=1, err=0.
2. Stream started mid-frame at (300,200) → no summary until the first complete frame following a (0,0) pixel.
3. Pixel (5,10) replaced by (6,10) → that frame err=1; the following clean frame err=0.
4. (0,0) injected after line 100 → truncated summary with err=1 published; the next full frame reports normally.
5. frm_ready held 0 across two frame ends → first summary held unchanged, second dropped, frm_drop=1. Raise ready → one transfer, then frm_valid=0.
6. All-blue frame with CRC_EN → found=0, key_cnt=0, min=10'h3FF, max=0; frm_crc equals the golden-model value. Same frame without CRC_EN → frm_crc=0.
